// File: rtl/ahb_switch_bank.sv
// ahb_switch_bank: AHB-Lite slave for a bank of switch/button inputs.
// Each channel is synchronised and debounced, and its rise/fall edges are detected.
// Edges set write-1-to-clear pending flags, which drive a masked level interrupt.
// Bus accesses complete in one cycle with no wait states.
//
// Bus handshake: HREADY is the pipeline-advance strobe. An address phase
// (HSEL, HADDR, HTRANS, HWRITE) is captured only on a cycle where HREADY=1,
// and is valid when HSEL=1 and HTRANS[1]=1. Its data phase is the following
// cycle. A write commits at the edge that closes the data phase, which requires
// HREADY=1. This slave never stalls, so HREADYOUT is tied to 1.
module ahb_switch_bank #(
  parameter int NUM_SW          = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic                HREADY,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [31:0]         HWDATA,
  output logic                HREADYOUT,
  output logic [31:0]         HRDATA,
  input  logic [NUM_SW-1:0]   SW_IN,
  output logic                IRQ
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_RAW      = 3'd1;
  localparam logic [2:0] REG_IRQ_EN   = 3'd2;
  localparam logic [2:0] REG_RISE_PND = 3'd3;
  localparam logic [2:0] REG_FALL_PND = 3'd4;

  logic [SYNC_STAGES-1:0][NUM_SW-1:0] sync_q, sync_d;
  logic [NUM_SW-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NUM_SW-1:0]                  data_q, data_d;
  logic [NUM_SW-1:0]                  irq_en_q, irq_en_d;
  logic [NUM_SW-1:0]                  rise_pnd_q, rise_pnd_d;
  logic [NUM_SW-1:0]                  fall_pnd_q, fall_pnd_d;
  logic                               irq_q, irq_d;
  logic                               a_valid_q, a_valid_d;
  logic                               a_write_q, a_write_d;
  logic [2:0]                         a_addr_q, a_addr_d;

  logic [NUM_SW-1:0] raw;
  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] fall;
  logic [NUM_SW-1:0] wr_bits;
  logic              wr_fire;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign raw     = sync_q[SYNC_STAGES-1];
  assign wr_fire = a_valid_q & a_write_q & HREADY;
  assign wr_bits = HWDATA[NUM_SW-1:0];

  // Size, upper/lower address bits and HTRANS[0] carry no meaning for this block.
  assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  // Shift raw inputs through the synchroniser chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = SW_IN;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if (raw[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        data_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Edge flags, W1C clears (a same-cycle set beats the clear), enable writes, masked IRQ.
  always_comb begin
    rise       = data_d & ~data_q;
    fall       = data_q & ~data_d;
    irq_en_d   = irq_en_q;
    rise_pnd_d = rise_pnd_q | rise;
    fall_pnd_d = fall_pnd_q | fall;
    if (wr_fire) begin
      case (a_addr_q)
        REG_IRQ_EN:   irq_en_d   = wr_bits;
        REG_RISE_PND: rise_pnd_d = (rise_pnd_q & ~wr_bits) | rise;
        REG_FALL_PND: fall_pnd_d = (fall_pnd_q & ~wr_bits) | fall;
        default:      ;
      endcase
    end
    irq_d = |((rise_pnd_q | fall_pnd_q) & irq_en_q);
  end

  // Capture the address phase whenever the bus advances.
  always_comb begin
    a_valid_d = a_valid_q;
    a_write_d = a_write_q;
    a_addr_d  = a_addr_q;
    if (HREADY) begin
      a_valid_d = HSEL & HTRANS[1];
      a_write_d = HWRITE;
      a_addr_d  = HADDR[4:2];
    end
  end

  // Read mux from the captured address and current register contents.
  always_comb begin
    rd_word = '0;
    if (a_valid_q && !a_write_q) begin
      case (a_addr_q)
        REG_DATA:     rd_word[NUM_SW-1:0] = data_q;
        REG_RAW:      rd_word[NUM_SW-1:0] = raw;
        REG_IRQ_EN:   rd_word[NUM_SW-1:0] = irq_en_q;
        REG_RISE_PND: rd_word[NUM_SW-1:0] = rise_pnd_q;
        REG_FALL_PND: rd_word[NUM_SW-1:0] = fall_pnd_q;
        default:      rd_word = '0;
      endcase
    end
  end

  // State registers; reset discards any partial debounce count.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      irq_en_q   <= '0;
      rise_pnd_q <= '0;
      fall_pnd_q <= '0;
      irq_q      <= 1'b0;
      a_valid_q  <= 1'b0;
      a_write_q  <= 1'b0;
      a_addr_q   <= '0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      irq_en_q   <= irq_en_d;
      rise_pnd_q <= rise_pnd_d;
      fall_pnd_q <= fall_pnd_d;
      irq_q      <= irq_d;
      a_valid_q  <= a_valid_d;
      a_write_q  <= a_write_d;
      a_addr_q   <= a_addr_d;
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRDATA    = rd_word;
  assign IRQ       = irq_q;

endmodule
